// File: rtl/stream_arb_pkg.sv
// Shared definitions for stream_fifo_arbiter: FSM state encoding, clog2 and
// the round-robin pick used by rr_arbiter.
package stream_arb_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Returns {valid, index}; req bits above the real source count must be zero,
  // which makes the 8-wide wrap equivalent to a wrap modulo the source count.
  function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
    logic [3:0] pick;
    logic [2:0] idx;
    pick = '0;
    for (int k = 7; k >= 0; k--) begin
      idx = ptr + 3'(k);
      if (req[idx]) pick = {1'b1, idx};
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, with wrap.
module rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  logic [7:0] w_req;
  logic [2:0] w_ptr;
  logic [3:0] w_pick;
  logic       w_unused_pick;

  always_comb begin
    w_req = '0;
    w_req[NUM_SRC-1:0] = req;
    w_ptr = '0;
    w_ptr[IDX_W-1:0] = ptr;
  end

  assign w_pick        = rr_pick(w_req, w_ptr);
  assign gnt_vld       = w_pick[3];
  assign gnt_idx       = w_pick[IDX_W-1:0];
  assign w_unused_pick = ^w_pick;

endmodule

// File: rtl/stream_fifo_arbiter.sv
// Packet-locked round-robin arbiter from NUM_SRC AXI-Stream sources onto one FIFO
// write port. Optional stall timeout enabled by defining STREAM_ARB_TIMEOUT_EN.
module stream_fifo_arbiter
  import stream_arb_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NUM_SRC = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       fifo_full,
  output logic [WIDTH:0]             fifo_data,
  output logic                       fifo_wr,
  output logic [NUM_SRC-1:0]         s_axis_tready,
  input  logic [NUM_SRC-1:0]         s_axis_tvalid,
  input  logic [NUM_SRC*WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_SRC*WIDTH/8-1:0] s_axis_tkeep,
  input  logic [NUM_SRC-1:0]         s_axis_tlast,
  output logic [clog2(NUM_SRC)-1:0]  grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int IDX_W  = clog2(NUM_SRC);
  localparam int KEEP_W = WIDTH / 8;

  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_grant;
  logic [IDX_W-1:0] w_arb_idx;
  logic [IDX_W-1:0] w_next_ptr;
  logic             w_arb_vld;
  logic             w_lock;
  logic             w_gvalid;
  logic             w_glast;
  logic [WIDTH-1:0] w_gdata;
  logic [KEEP_W-1:0] w_gkeep;
  logic             w_accept;
  logic             w_done;
  logic             w_revoke;

  rr_arbiter #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_rr_arbiter (
    .req     (s_axis_tvalid),
    .ptr     (r_rr_ptr),
    .gnt_idx (w_arb_idx),
    .gnt_vld (w_arb_vld)
  );

  assign w_lock   = (r_state == ST_LOCK);
  assign w_gvalid = s_axis_tvalid[r_grant];
  assign w_glast  = s_axis_tlast[r_grant];
  assign w_gdata  = s_axis_tdata[int'(r_grant)*WIDTH +: WIDTH];
  assign w_gkeep  = s_axis_tkeep[int'(r_grant)*KEEP_W +: KEEP_W];

  // Zero-keep beats still handshake so a null tlast beat can close a packet.
  assign w_accept  = w_lock & w_gvalid & ~fifo_full;
  assign w_done    = w_accept & w_glast;
  assign fifo_wr   = w_accept & (|w_gkeep);
  assign fifo_data = w_lock ? {w_glast, w_gdata} : '0;
  assign busy      = w_lock;
  assign grant_id  = r_grant;

  always_comb begin
    s_axis_tready = '0;
    if (w_lock) s_axis_tready[r_grant] = ~fifo_full;
  end

  assign w_next_ptr = (r_grant == IDX_W'(NUM_SRC - 1)) ? '0 : r_grant + 1'b1;

`ifdef STREAM_ARB_TIMEOUT_EN
  localparam int CNT_W = clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_stall;
  logic             r_timeout_err;

  assign w_revoke    = w_lock & ~w_accept & (r_stall == CNT_W'(TIMEOUT - 1));
  assign timeout_err = r_timeout_err;

  // Held at zero while idle, which also covers the clear on entering LOCK.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall       <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_revoke;
      if (!w_lock || w_accept) r_stall <= '0;
      else if (r_stall != CNT_W'(TIMEOUT)) r_stall <= r_stall + 1'b1;
    end
  end
`else
  logic w_unused_timeout;

  assign w_revoke         = 1'b0;
  assign timeout_err      = 1'b0;
  assign w_unused_timeout = (TIMEOUT != 0);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_grant  <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_arb_vld) begin
        r_state <= ST_LOCK;
        r_grant <= w_arb_idx;
      end
    end else if (w_done || w_revoke) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= w_next_ptr;
    end
  end

endmodule

// File: tb/tb_stream_fifo_arbiter.sv
// Directed self-checking bench for stream_fifo_arbiter (4 sources, 16-bit data,
// TIMEOUT=16); the timeout scenario follows STREAM_ARB_TIMEOUT_EN.
module tb_stream_fifo_arbiter;

  localparam int WIDTH   = 16;
  localparam int NUM_SRC = 4;
  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rstn;
  logic        fifo_full;
  logic [16:0] fifo_data;
  logic        fifo_wr;
  logic [3:0]  s_axis_tready;
  logic [3:0]  s_axis_tvalid;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic [3:0]  s_axis_tlast;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;

  int assertCount = 0;
  int failCount   = 0;
  int cycleCnt    = 0;
  int toCount     = 0;
  int busyCycles;
  int srcLeft[4];
  int srcIdx[4];
  logic [16:0] wrData[$];
  int          wrCycle[$];
  logic [16:0] expSeq[5];

  stream_fifo_arbiter #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .fifo_full     (fifo_full),
    .fifo_data     (fifo_data),
    .fifo_wr       (fifo_wr),
    .s_axis_tready (s_axis_tready),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Writes and timeout pulses are captured mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (fifo_wr) begin
      wrData.push_back(fifo_data);
      wrCycle.push_back(cycleCnt);
    end
    if (timeout_err) toCount <= toCount + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int s, input logic v, input logic [15:0] d,
                               input logic [1:0] k, input logic l);
    s_axis_tvalid[s]         = v;
    s_axis_tdata[s*16 +: 16] = d;
    s_axis_tkeep[s*2 +: 2]   = k;
    s_axis_tlast[s]          = l;
  endtask

  task automatic nextEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rstn          = 1'b0;
    fifo_full     = 1'b0;
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = '0;
    for (int s = 0; s < 4; s++) begin
      srcLeft[s] = 0;
      srcIdx[s]  = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Packet sources: data is {source, beat index}, tlast on the final beat.
  task automatic updateSources();
    for (int s = 0; s < 4; s++) begin
      if (srcLeft[s] > 0)
        applyStimulus(s, 1'b1, {4'(s), 12'(srcIdx[s])}, 2'b11, srcLeft[s] == 1);
      else
        applyStimulus(s, 1'b0, 16'h0, 2'b00, 1'b0);
    end
  endtask

  task automatic driveCycle();
    logic [3:0] fire;
    @(negedge clk);
    fire = s_axis_tready & s_axis_tvalid;
    nextEdge();
    for (int s = 0; s < 4; s++) begin
      if (fire[s]) begin
        srcLeft[s]--;
        srcIdx[s]++;
      end
    end
    updateSources();
  endtask

  initial begin
    // Reset state and a simple 3-beat packet from source 0
    resetDut();
    wrData.delete();
    wrCycle.delete();
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_grant", grant_id, 0);
    checkOutput("rst_tready", s_axis_tready, 0);
    checkOutput("rst_wr", fifo_wr, 0);
    checkOutput("rst_data", fifo_data, 0);
    checkOutput("rst_timeout", timeout_err, 0);
    nextEdge();
    applyStimulus(0, 1'b1, 16'hA001, 2'b11, 1'b0);
    @(negedge clk);
    checkOutput("t1_idle_tready", s_axis_tready, 0);
    checkOutput("t1_idle_busy", busy, 0);
    nextEdge();
    @(negedge clk);
    checkOutput("t1_busy", busy, 1);
    checkOutput("t1_grant", grant_id, 0);
    checkOutput("t1_tready", s_axis_tready, 4'b0001);
    checkOutput("t1_wr1", fifo_wr, 1);
    checkOutput("t1_data1", fifo_data, 17'h0A001);
    nextEdge();
    applyStimulus(0, 1'b1, 16'hA002, 2'b11, 1'b0);
    @(negedge clk);
    checkOutput("t1_wr2", fifo_wr, 1);
    nextEdge();
    applyStimulus(0, 1'b1, 16'hA003, 2'b11, 1'b1);
    @(negedge clk);
    checkOutput("t1_wr3", fifo_wr, 1);
    checkOutput("t1_last3", fifo_data[16], 1);
    nextEdge();
    applyStimulus(0, 1'b0, 16'h0, 2'b00, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("t1_done_busy", busy, 0);
    checkOutput("t1_wr_count", wrData.size(), 3);
    checkOutput("t1_q2", wrData[2], 17'h1A003);

    // Sources 1 and 2 compete from rr_ptr=0
    resetDut();
    wrData.delete();
    wrCycle.delete();
    srcLeft[1] = 3;
    srcLeft[2] = 2;
    updateSources();
    for (int c = 0; c < 40 && (srcLeft[1] + srcLeft[2]) > 0; c++) driveCycle();
    @(negedge clk);
    #1;
    checkOutput("t2_sources_drained", srcLeft[1] + srcLeft[2], 0);
    checkOutput("t2_wr_count", wrData.size(), 5);
    expSeq[0] = 17'h01000;
    expSeq[1] = 17'h01001;
    expSeq[2] = 17'h11002;
    expSeq[3] = 17'h02000;
    expSeq[4] = 17'h12001;
    for (int i = 0; i < 5; i++) checkOutput($sformatf("t2_beat%0d", i), wrData[i], expSeq[i]);
    checkOutput("t2_rearb_gap", wrCycle[3] - wrCycle[2], 2);
    checkOutput("t2_src1_back2back", wrCycle[2] - wrCycle[0], 2);

    // FIFO full for 5 cycles mid-packet
    wrData.delete();
    nextEdge();
    applyStimulus(0, 1'b1, 16'hB000, 2'b11, 1'b0);
    nextEdge();
    @(negedge clk);
    checkOutput("t3_wr_first", fifo_wr, 1);
    nextEdge();
    applyStimulus(0, 1'b1, 16'hB001, 2'b11, 1'b0);
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t3_full_tready%0d", i), s_axis_tready, 0);
      checkOutput($sformatf("t3_full_wr%0d", i), fifo_wr, 0);
      checkOutput($sformatf("t3_full_busy%0d", i), busy, 1);
      nextEdge();
    end
    fifo_full = 1'b0;
    @(negedge clk);
    checkOutput("t3_resume_wr", fifo_wr, 1);
    checkOutput("t3_resume_data", fifo_data, 17'h0B001);
    nextEdge();
    applyStimulus(0, 1'b1, 16'hB002, 2'b11, 1'b1);
    nextEdge();
    applyStimulus(0, 1'b0, 16'h0, 2'b00, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("t3_wr_count", wrData.size(), 3);
    checkOutput("t3_q1", wrData[1], 17'h0B001);
    checkOutput("t3_q2", wrData[2], 17'h1B002);

    // Null-keep tlast beat closes a packet without a write; rr_ptr then 3
    nextEdge();
    applyStimulus(2, 1'b1, 16'hD000, 2'b00, 1'b1);
    nextEdge();
    @(negedge clk);
    checkOutput("t4_tready", s_axis_tready, 4'b0100);
    checkOutput("t4_wr", fifo_wr, 0);
    nextEdge();
    applyStimulus(2, 1'b0, 16'h0, 2'b00, 1'b0);
    @(negedge clk);
    checkOutput("t4_idle", busy, 0);
    nextEdge();
    applyStimulus(0, 1'b1, 16'hC000, 2'b11, 1'b1);
    applyStimulus(2, 1'b1, 16'hD001, 2'b11, 1'b0);
    nextEdge();
    @(negedge clk);
    checkOutput("t4_ptr_adv_grant", grant_id, 0);
    checkOutput("t4_wr_c000", fifo_data, 17'h1C000);
    nextEdge();
    applyStimulus(0, 1'b0, 16'h0, 2'b00, 1'b0);
    applyStimulus(2, 1'b0, 16'h0, 2'b00, 1'b0);
    @(negedge clk);
    checkOutput("t4_done_busy", busy, 0);

    // Source 3 stalls after one beat without tlast
    nextEdge();
    toCount = 0;
    applyStimulus(3, 1'b1, 16'hE000, 2'b11, 1'b0);
    nextEdge();
    @(negedge clk);
    checkOutput("t5_wr", fifo_wr, 1);
    checkOutput("t5_grant", grant_id, 3);
    nextEdge();
    applyStimulus(3, 1'b0, 16'h0, 2'b00, 1'b0);
`ifdef STREAM_ARB_TIMEOUT_EN
    busyCycles = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!busy) break;
      busyCycles++;
      nextEdge();
    end
    checkOutput("t5_stall_cycles", busyCycles, 16);
    checkOutput("t5_revoked", busy, 0);
    repeat (4) @(negedge clk);
    #1;
    checkOutput("t5_pulses", toCount, 1);
    nextEdge();
    applyStimulus(0, 1'b1, 16'hC100, 2'b11, 1'b1);
    nextEdge();
    @(negedge clk);
    checkOutput("t5_next_grant", grant_id, 0);
    checkOutput("t5_next_busy", busy, 1);
    nextEdge();
    applyStimulus(0, 1'b0, 16'h0, 2'b00, 1'b0);
`else
    repeat (40) @(negedge clk);
    #1;
    checkOutput("t5_held_busy", busy, 1);
    checkOutput("t5_held_grant", grant_id, 3);
    checkOutput("t5_no_pulse", toCount, 0);
    nextEdge();
    applyStimulus(3, 1'b1, 16'hE001, 2'b11, 1'b1);
    @(negedge clk);
    checkOutput("t5_close_wr", fifo_wr, 1);
    nextEdge();
    applyStimulus(3, 1'b0, 16'h0, 2'b00, 1'b0);
`endif

    // Async reset mid-packet; a packet from source 2 first leaves rr_ptr at 3
    nextEdge();
    applyStimulus(2, 1'b1, 16'hF000, 2'b11, 1'b1);
    nextEdge();
    nextEdge();
    applyStimulus(2, 1'b0, 16'h0, 2'b00, 1'b0);
    nextEdge();
    applyStimulus(1, 1'b1, 16'hF100, 2'b11, 1'b0);
    nextEdge();
    @(negedge clk);
    checkOutput("t6_pre_grant", grant_id, 1);
    checkOutput("t6_pre_wr", fifo_wr, 1);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_wr", fifo_wr, 0);
    checkOutput("t6_rst_tready", s_axis_tready, 0);
    checkOutput("t6_rst_data", fifo_data, 0);
    checkOutput("t6_rst_grant", grant_id, 0);
    checkOutput("t6_rst_timeout", timeout_err, 0);
    applyStimulus(1, 1'b0, 16'h0, 2'b00, 1'b0);
    #1;
    rstn = 1'b1;
    nextEdge();
    applyStimulus(0, 1'b1, 16'h0A0A, 2'b11, 1'b1);
    applyStimulus(3, 1'b1, 16'h3A3A, 2'b11, 1'b1);
    @(negedge clk);
    checkOutput("t6_post_idle", busy, 0);
    nextEdge();
    @(negedge clk);
    checkOutput("t6_post_ptr0_grant", grant_id, 0);
    checkOutput("t6_post_data", fifo_data, 17'h10A0A);
    nextEdge();
    applyStimulus(0, 1'b0, 16'h0, 2'b00, 1'b0);
    applyStimulus(3, 1'b0, 16'h0, 2'b00, 1'b0);
    repeat (3) nextEdge();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
